coeff_mem_arbiter: RTL and testbench

//   Shares the single-port coefficient SRAM (mem: 16b addr, 24b data, active-low WEB/CEB, 1-cycle read latency)

---
 rtl/dilithium_mem_pkg.sv | 17 +
 rtl/coeff_mem_arbiter_if.sv | 28 ++
 rtl/rr_pick.sv | 32 +++
 rtl/coeff_mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_coeff_mem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dilithium_mem_pkg.sv
// Shared constants for the coefficient SRAM arbiter: SRAM geometry, requester IDs
// and the arbiter FSM state encoding.
package dilithium_mem_pkg;

  localparam int MEM_AW = 16;
  localparam int MEM_DW = 24;

  localparam int REQ_EXPANDA = 0;
  localparam int REQ_NTT     = 1;
  localparam int REQ_HOST    = 2;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/coeff_mem_arbiter_if.sv
// Requester-side bundle of the coefficient SRAM arbiter: packed per-requester
// request/address/data in, one-hot grant and read-valid plus shared read data out.
interface coeff_mem_arbiter_if
  import dilithium_mem_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = MEM_AW,
  parameter int DW   = MEM_DW
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    lock;
  logic [NREQ-1:0]    we;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rvalid;
  logic [DW-1:0]      rdata;

  modport master (
    output req, lock, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, lock, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after i_ptr,
// wrapping modulo N; returns one-hot, index and an any-request flag.
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_onehot,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  int w_j;

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    w_j      = 0;
    for (int i = 0; i < N; i++) begin
      w_j = int'(i_ptr) + i;
      if (w_j >= N) w_j = w_j - N;
      if (!o_any && i_req[w_j]) begin
        o_any         = 1'b1;
        o_idx         = IW'(w_j);
        o_onehot[w_j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/coeff_mem_arbiter.sv
// Round-robin arbiter with burst lock sharing the single-port coefficient SRAM.
// Optional per-requester wait-cycle counters are built when MEM_ARB_STATS_EN is defined.
module coeff_mem_arbiter
  import dilithium_mem_pkg::*;
#(
  parameter int NREQ      = 3,
  parameter int AW        = MEM_AW,
  parameter int DW        = MEM_DW,
  parameter int MAX_BURST = 16
) (
  input  logic          clk,
  input  logic          rst,
  coeff_mem_arbiter_if.slave arb,
  output logic [AW-1:0] o_mem_A,
  output logic [DW-1:0] o_mem_D,
  output logic          o_mem_WEB,
  output logic          o_mem_CEB,
  input  logic [DW-1:0] i_mem_Q,
`ifdef MEM_ARB_STATS_EN
  input  logic          i_stat_clr,
  input  logic [2:0]    i_stat_sel,
  output logic [15:0]   o_stat_out,
`endif
  output logic          o_busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);

  arb_state_e      r_state, w_state_nxt;
  logic [IW-1:0]   r_owner, w_owner_nxt;
  logic [IW-1:0]   r_rr_ptr, w_rr_ptr_nxt;
  logic [BW-1:0]   r_burst_cnt, w_burst_nxt;
  logic [NREQ-1:0] r_rvalid;

  logic [NREQ-1:0] w_gnt;
  logic [IW-1:0]   w_gidx;
  logic            w_gany;
  logic            w_hold;
  logic            w_issue;
  logic [IW-1:0]   w_pick_ptr;
  logic [NREQ-1:0] w_pick_oh;
  logic [IW-1:0]   w_pick_idx;
  logic            w_pick_any;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
    if (int'(v) >= NREQ - 1) return '0;
    return v + 1'b1;
  endfunction

  assign w_hold = (r_state == ARB_LOCKED) && arb.req[r_owner] && arb.lock[r_owner] &&
                  (r_burst_cnt < BW'(MAX_BURST));

  // Leaving a burst re-arbitrates in the same cycle from the slot after the owner
  assign w_pick_ptr = (r_state == ARB_LOCKED) ? wrap_inc(r_owner) : r_rr_ptr;

  rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .i_req    (arb.req),
    .i_ptr    (w_pick_ptr),
    .o_onehot (w_pick_oh),
    .o_idx    (w_pick_idx),
    .o_any    (w_pick_any)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_rr_ptr_nxt = r_rr_ptr;
    w_burst_nxt  = r_burst_cnt;
    w_gnt        = '0;
    w_gidx       = r_owner;
    w_gany       = 1'b0;
    if (w_hold) begin
      w_gnt[r_owner] = 1'b1;
      w_gany         = 1'b1;
      w_burst_nxt    = r_burst_cnt + 1'b1;
    end else begin
      w_state_nxt  = ARB_IDLE;
      w_rr_ptr_nxt = w_pick_ptr;
      w_burst_nxt  = '0;
      if (w_pick_any) begin
        w_gnt  = w_pick_oh;
        w_gidx = w_pick_idx;
        w_gany = 1'b1;
        if (arb.lock[w_pick_idx]) begin
          w_state_nxt = ARB_LOCKED;
          w_owner_nxt = w_pick_idx;
          w_burst_nxt = BW'(1);
        end else begin
          w_rr_ptr_nxt = wrap_inc(w_pick_idx);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ARB_IDLE;
      r_owner     <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
      r_rvalid    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_owner     <= w_owner_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_burst_cnt <= w_burst_nxt;
      r_rvalid    <= arb.gnt & ~arb.we;
    end
  end

  // Grants and read-valid are masked while reset is held so an aborted read never reports
  assign w_issue    = w_gany & ~rst;
  assign arb.gnt    = rst ? '0 : w_gnt;
  assign arb.rvalid = r_rvalid & {NREQ{~rst}};
  assign arb.rdata  = i_mem_Q;

  assign o_mem_CEB = ~w_issue;
  assign o_mem_WEB = w_issue ? ~arb.we[w_gidx] : 1'b1;
  assign o_mem_A   = w_issue ? arb.addr[w_gidx*AW +: AW] : '0;
  assign o_mem_D   = w_issue ? arb.wdata[w_gidx*DW +: DW] : '0;
  assign o_busy    = (r_state == ARB_LOCKED) || (|arb.req);

`ifdef MEM_ARB_STATS_EN
  logic [15:0] r_stat_cnt [NREQ];
  logic [15:0] r_stat_out;
  logic [15:0] w_stat_mux;

  always_comb begin
    w_stat_mux = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (int'(i_stat_sel) == k) w_stat_mux = r_stat_cnt[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_stat_clr) begin
      for (int k = 0; k < NREQ; k++) r_stat_cnt[k] <= '0;
      r_stat_out <= '0;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (arb.req[k] && !arb.gnt[k] && (r_stat_cnt[k] != 16'hFFFF))
          r_stat_cnt[k] <= r_stat_cnt[k] + 16'd1;
      end
      r_stat_out <= w_stat_mux;
    end
  end

  assign o_stat_out = r_stat_out;
`endif

endmodule

// File: tb/tb_coeff_mem_arbiter.sv
// Directed bench for coeff_mem_arbiter with a behavioural SRAM and a read-data scoreboard.
module tb_coeff_mem_arbiter;
  import dilithium_mem_pkg::*;

  localparam int NREQ = 3;
  localparam int AW   = 16;
  localparam int DW   = 24;

  typedef struct {
    int          id;
    logic [23:0] data;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  coeff_mem_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) arb();

  logic [AW-1:0] mem_A;
  logic [DW-1:0] mem_D;
  logic [DW-1:0] mem_Q;
  logic          mem_WEB, mem_CEB, busy;
`ifdef MEM_ARB_STATS_EN
  logic          stat_clr;
  logic [2:0]    stat_sel;
  logic [15:0]   stat_out;
`endif

  coeff_mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .MAX_BURST(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .arb        (arb),
    .o_mem_A    (mem_A),
    .o_mem_D    (mem_D),
    .o_mem_WEB  (mem_WEB),
    .o_mem_CEB  (mem_CEB),
    .i_mem_Q    (mem_Q),
`ifdef MEM_ARB_STATS_EN
    .i_stat_clr (stat_clr),
    .i_stat_sel (stat_sel),
    .o_stat_out (stat_out),
`endif
    .o_busy     (busy)
  );

  // Behavioural single-port SRAM, one-cycle read latency
  logic [DW-1:0] sram [0:65535];
  logic          pre_we;
  logic [AW-1:0] pre_a;
  logic [DW-1:0] pre_d;
  always @(posedge clk) begin
    if (pre_we) sram[pre_a] <= pre_d;
    else if (!mem_CEB) begin
      if (!mem_WEB) sram[mem_A] <= mem_D;
      else          mem_Q <= sram[mem_A];
    end
  end

  int  n_cmp  = 0;
  int  n_fail = 0;
  bit  mon_en = 1'b0;
  sb_t sb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive(input int k, input logic r, input logic l, input logic w,
                       input logic [15:0] a, input logic [23:0] d);
    arb.req[k]            = r;
    arb.lock[k]           = l;
    arb.we[k]             = w;
    arb.addr[k*AW +: AW]  = a;
    arb.wdata[k*DW +: DW] = d;
  endtask

  task automatic clear_all();
    arb.req  = '0;
    arb.lock = '0;
    arb.we   = '0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Scoreboard: every rvalid must match the oldest expected read
  always @(negedge clk) begin
    if (mon_en && (arb.rvalid !== 3'b000)) begin
      n_cmp++;
      assert (sb_q.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_unexpected: observed rvalid %b expected none", arb.rvalid);
      end
      if (sb_q.size() != 0) begin
        sb_t e;
        logic [2:0] exp_v;
        e = sb_q.pop_front();
        exp_v = 3'b000;
        exp_v[e.id] = 1'b1;
        chk("sb_rvalid", 32'(arb.rvalid), 32'(exp_v));
        chk("sb_rdata", 32'(arb.rdata), 32'(e.data));
      end
    end
  end

  initial begin
    logic [2:0] exp_g;
    clear_all();
    arb.addr  = '0;
    arb.wdata = '0;
    pre_we    = 1'b0;
    pre_a     = '0;
    pre_d     = '0;
`ifdef MEM_ARB_STATS_EN
    stat_clr = 1'b0;
    stat_sel = 3'd0;
`endif
    // preload SRAM[0x0010] = 0x00ABCD
    pre_we = 1'b1; pre_a = 16'h0010; pre_d = 24'h00ABCD;
    tick();
    pre_we = 1'b0;
    tick();
    sample();
    chk("rst_gnt", 32'(arb.gnt), 32'h0);
    chk("rst_ceb", 32'(mem_CEB), 32'h1);
    chk("rst_web", 32'(mem_WEB), 32'h1);
    tick();
    rst = 1'b0;
    mon_en = 1'b1;
    sample();
    chk("idle_rvalid", 32'(arb.rvalid), 32'h0);
    chk("idle_A", 32'(mem_A), 32'h0);
    chk("idle_D", 32'(mem_D), 32'h0);
    chk("idle_busy", 32'(busy), 32'h0);

    // 1. single read from NTT
    tick();
    drive(REQ_NTT, 1'b1, 1'b0, 1'b0, 16'h0010, 24'h0);
    sample();
    chk("t1_gnt", 32'(arb.gnt), 32'h2);
    chk("t1_ceb", 32'(mem_CEB), 32'h0);
    chk("t1_web", 32'(mem_WEB), 32'h1);
    chk("t1_A", 32'(mem_A), 32'h0010);
    sb_q.push_back('{id: REQ_NTT, data: 24'h00ABCD});
    tick();
    clear_all();
    sample();
    chk("t1_rvalid", 32'(arb.rvalid), 32'h2);
    chk("t1_rdata", 32'(arb.rdata), 32'h00ABCD);
    chk("t1_ceb_after", 32'(mem_CEB), 32'h1);

    // 2. all three requesting writes, no lock
    tick();
    pulse_reset();
    drive(REQ_EXPANDA, 1'b1, 1'b0, 1'b1, 16'h0100, 24'h000111);
    drive(REQ_NTT,     1'b1, 1'b0, 1'b1, 16'h0101, 24'h000222);
    drive(REQ_HOST,    1'b1, 1'b0, 1'b1, 16'h0102, 24'h000333);
    for (int i = 0; i < 6; i++) begin
      sample();
      exp_g = 3'b000;
      exp_g[i % 3] = 1'b1;
      chk("t2_gnt", 32'(arb.gnt), 32'(exp_g));
      chk("t2_A", 32'(mem_A), 32'h0100 + 32'(i % 3));
      tick();
    end
    clear_all();

    // 3. locked burst from ExpandA against host
    pulse_reset();
    drive(REQ_EXPANDA, 1'b1, 1'b1, 1'b1, 16'h0200, 24'h0000AA);
    drive(REQ_HOST,    1'b1, 1'b0, 1'b1, 16'h0202, 24'h0000BB);
    for (int i = 0; i < 16; i++) begin
      sample();
      chk("t3_burst_gnt", 32'(arb.gnt), 32'h1);
      tick();
    end
    sample();
    chk("t3_forced_gnt", 32'(arb.gnt), 32'h4);
    tick();
    sample();
    chk("t3_regrant", 32'(arb.gnt), 32'h1);
    chk("t3_busy", 32'(busy), 32'h1);
    tick();
    clear_all();
    tick();

    // 4. host write then readback at top address
    drive(REQ_HOST, 1'b1, 1'b0, 1'b1, 16'hFFFF, 24'h123456);
    sample();
    chk("t4_wr_gnt", 32'(arb.gnt), 32'h4);
    chk("t4_wr_web", 32'(mem_WEB), 32'h0);
    chk("t4_wr_A", 32'(mem_A), 32'hFFFF);
    chk("t4_wr_D", 32'(mem_D), 32'h123456);
    tick();
    arb.we[REQ_HOST] = 1'b0;
    sample();
    chk("t4_rd_gnt", 32'(arb.gnt), 32'h4);
    chk("t4_rd_web", 32'(mem_WEB), 32'h1);
    sb_q.push_back('{id: REQ_HOST, data: 24'h123456});
    tick();
    clear_all();
    sample();
    chk("t4_rvalid", 32'(arb.rvalid), 32'h4);
    chk("t4_rdata", 32'(arb.rdata), 32'h123456);

    // 5. reset right after a read grant
    tick();
    drive(REQ_NTT, 1'b1, 1'b0, 1'b0, 16'h0010, 24'h0);
    sample();
    chk("t5_gnt", 32'(arb.gnt), 32'h2);
    tick();
    rst = 1'b1;
    clear_all();
    sample();
    chk("t5_rvalid_rst", 32'(arb.rvalid), 32'h0);
    chk("t5_gnt_rst", 32'(arb.gnt), 32'h0);
    tick();
    rst = 1'b0;
    drive(REQ_NTT,  1'b1, 1'b0, 1'b1, 16'h0300, 24'h0);
    drive(REQ_HOST, 1'b1, 1'b0, 1'b1, 16'h0302, 24'h0);
    sample();
    chk("t5_ptr0", 32'(arb.gnt), 32'h2);
    chk("t5_rvalid_after", 32'(arb.rvalid), 32'h0);
    tick();
    arb.req[REQ_NTT] = 1'b0;
    sample();
    chk("t5_host", 32'(arb.gnt), 32'h4);
    tick();
    clear_all();

`ifdef MEM_ARB_STATS_EN
    // 6. wait-cycle counter for NTT blocked by ExpandA burst
    pulse_reset();
    drive(REQ_EXPANDA, 1'b1, 1'b1, 1'b1, 16'h0400, 24'h0);
    drive(REQ_NTT,     1'b1, 1'b0, 1'b1, 16'h0401, 24'h0);
    for (int i = 0; i < 5; i++) begin
      sample();
      chk("t6_gnt", 32'(arb.gnt), 32'h1);
      tick();
    end
    arb.req[REQ_NTT] = 1'b0;
    stat_sel = 3'd1;
    tick();
    sample();
    chk("t6_stat", 32'(stat_out), 32'd5);
    stat_sel = 3'd5;
    tick();
    sample();
    chk("t6_stat_oor", 32'(stat_out), 32'd0);
    stat_sel = 3'd1;
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    clear_all();
    sample();
    chk("t6_stat_clr", 32'(stat_out), 32'd0);
    tick();
`endif

    tick();
    sample();
    chk("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
